// File: rtl/iter_mdu_pkg.sv
// Shared MDU opcodes, default multiply latency, FSM state type and opcode
// classification helpers used by the decoder, hazard unit and iter_mdu.
package iter_mdu_pkg;

    localparam int MDUOP_SIZE          = 4;
    localparam int MDU_DEFAULT_LATENCY = 5;

    localparam logic [MDUOP_SIZE-1:0] MDUOP_NOOP  = 4'd0;
    localparam logic [MDUOP_SIZE-1:0] MDUOP_MULT  = 4'd1;
    localparam logic [MDUOP_SIZE-1:0] MDUOP_MULTU = 4'd2;
    localparam logic [MDUOP_SIZE-1:0] MDUOP_DIV   = 4'd3;
    localparam logic [MDUOP_SIZE-1:0] MDUOP_DIVU  = 4'd4;
    localparam logic [MDUOP_SIZE-1:0] MDUOP_MTHI  = 4'd5;
    localparam logic [MDUOP_SIZE-1:0] MDUOP_MTLO  = 4'd6;
    localparam logic [MDUOP_SIZE-1:0] MDUOP_MADD  = 4'd7;
    localparam logic [MDUOP_SIZE-1:0] MDUOP_MADDU = 4'd8;
    localparam logic [MDUOP_SIZE-1:0] MDUOP_MSUB  = 4'd9;
    localparam logic [MDUOP_SIZE-1:0] MDUOP_MSUBU = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [MDUOP_SIZE-1:0] op);
        return op inside {MDUOP_MULT, MDUOP_MULTU, MDUOP_MADD, MDUOP_MADDU,
                          MDUOP_MSUB, MDUOP_MSUBU};
    endfunction

    function automatic logic is_div_op(input logic [MDUOP_SIZE-1:0] op);
        return op inside {MDUOP_DIV, MDUOP_DIVU};
    endfunction

    function automatic logic is_signed_op(input logic [MDUOP_SIZE-1:0] op);
        return op inside {MDUOP_MULT, MDUOP_DIV, MDUOP_MADD, MDUOP_MSUB};
    endfunction

endpackage

// File: rtl/iter_mdu_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface iter_mdu_if
    import iter_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    logic [MDUOP_SIZE-1:0] op;
    logic [WIDTH-1:0]      operand1;
    logic [WIDTH-1:0]      operand2;
    logic                  cancel;
    logic [WIDTH-1:0]      HI;
    logic [WIDTH-1:0]      LO;
    logic                  start;
    logic                  busy;

    modport master (output op, operand1, operand2, cancel,
                    input  HI, LO, start, busy);
    modport slave  (input  op, operand1, operand2, cancel,
                    output HI, LO, start, busy);
endinterface

// File: rtl/iter_mdu_div_iter.sv
// Restoring divider: one quotient bit per cycle, MSB first, on operand magnitudes,
// with sign fix-up applied to the result of the step in progress.
module mdu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] quo_step, rem_step;
    logic             dnd_neg, dvs_neg;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic neg);
        return neg ? (~x + WIDTH'(1)) : x;
    endfunction

    always_comb begin
        dnd_neg  = is_signed & dividend[WIDTH-1];
        dvs_neg  = is_signed & divisor[WIDTH-1];
        // A failed trial subtraction restores the shifted partial remainder.
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

        active_d = active_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        if (abort) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (start) begin
            active_d = 1'b1;
            cnt_d    = CNT_W'(WIDTH);
            quo_d    = cond_neg(dividend, dnd_neg);
            rem_d    = '0;
            dvs_d    = cond_neg(divisor, dvs_neg);
            qneg_d   = dnd_neg ^ dvs_neg;
            rneg_d   = dnd_neg;
        end else if (active_q) begin
            quo_d = quo_step;
            rem_d = rem_step;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign done      = active_q && (cnt_q == CNT_W'(1));
    assign quotient  = cond_neg(quo_step, qneg_q);
    assign remainder = cond_neg(rem_step, rneg_q);

endmodule

// File: rtl/iter_mdu.sv
// Multiply/divide unit with HI/LO: fixed-latency multiply (with accumulate and
// subtract modes), iterative restoring divide, MTHI/MTLO and flush cancel.
module iter_mdu
    import iter_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = MDU_DEFAULT_LATENCY
) (
    input logic       clk,
    input logic       reset,
    iter_mdu_if.slave bus
);
    localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MDUOP_SIZE-1:0] op_q, op_d;
    logic [WIDTH-1:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic                  div_start, div_done;
    logic [WIDTH-1:0]      div_quo, div_rem;

    function automatic logic [2*WIDTH-1:0] mul_result(
        input logic [MDUOP_SIZE-1:0] op,
        input logic [WIDTH-1:0] a, b, hi, lo);
        logic                      sgn;
        logic signed [2*WIDTH-1:0] ea, eb, prod, acc;
        sgn  = is_signed_op(op);
        ea   = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        eb   = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        prod = ea * eb;
        acc  = {hi, lo};
        case (op)
            MDUOP_MADD, MDUOP_MADDU: return acc + prod;
            MDUOP_MSUB, MDUOP_MSUBU: return acc - prod;
            default:                 return prod;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_start = 1'b0;
        // Flush beats everything: the presented op dies and any operation aborts.
        if (bus.cancel) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mul_op(bus.op) || is_div_op(bus.op)) begin
                        op_d = bus.op;
                        a_d  = bus.operand1;
                        b_d  = bus.operand2;
                    end
                    if (is_mul_op(bus.op)) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(MUL_LATENCY);
                    end else if (is_div_op(bus.op)) begin
                        state_d   = ST_DIV;
                        cnt_d     = CNT_W'(WIDTH);
                        div_start = 1'b1;
                    end else if (bus.op == MDUOP_MTHI) begin
                        hi_d = bus.operand1;
                    end else if (bus.op == MDUOP_MTLO) begin
                        lo_d = bus.operand1;
                    end
                end
                ST_MUL: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        {hi_d, lo_d} = mul_result(op_q, a_q, b_q, hi_q, lo_q);
                        state_d      = ST_IDLE;
                    end
                end
                ST_DIV: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // A zero divisor burns the full latency but leaves HI/LO alone.
                    if (div_done && (b_q != '0)) begin
                        hi_d = div_rem;
                        lo_d = div_quo;
                    end
                    if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MDUOP_NOOP;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    mdu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .abort     (bus.cancel),
        .is_signed (bus.op == MDUOP_DIV),
        .dividend  (bus.operand1),
        .divisor   (bus.operand2),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign bus.start = is_mul_op(bus.op) || is_div_op(bus.op);
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

endmodule

// File: doc/iter_mdu.md
# iter_mdu

Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core, replacing the fixed-delay MDU. Multiplies run a configurable fixed latency. Divides run a true iterative restoring divider, one quotient bit per cycle. Adds multiply-accumulate/subtract modes and an exception-flush cancel. HI/LO are held inside the block; the hazard unit stalls on `start || busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 2.
- `MUL_LATENCY`, 5: busy cycles for MULT/MULTU/MADD*/MSUB*; must be ≥ 1.
- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `op`  in  `MDUOP_SIZE`: operation from the decoder, one of the `MDUOP_*` codes.
- `operand1`  in  WIDTH: rs value (dividend / multiplicand / MTHI-MTLO data).
- `operand2`  in  WIDTH: rt value (divisor / multiplier).
- `cancel`  in  1: flush; kills the current `op` and aborts any in-flight operation.
- `HI`  out  WIDTH: HI register; reset 0.
- `LO`  out  WIDTH: LO register; reset 0.
- `start`  out  1: combinational; high when `op` is MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB or MSUBU, regardless of `cancel`.
- `busy`  out  1: registered; reset 0.

## Operation
- FSM states: IDLE, MUL, DIV. Reset → IDLE, counter 0, operand latches 0.
- **IDLE, start op, no cancel:** latch operands and op.
  - Mul ops: go to MUL with count = MUL_LATENCY.
  - Div ops: go to DIV with count = WIDTH.
- **IDLE, MTHI/MTLO, no cancel:** write `operand1` to HI/LO at that edge; stay in IDLE.
- **MUL:** decrement count each cycle. On the edge where count = 1, write HI/LO and return to IDLE:
  - MULT: {HI,LO} = signed product, 2·WIDTH bits.
  - MULTU: {HI,LO} = unsigned product.
  - MADD/MADDU: {HI,LO} += product, modulo 2^(2·WIDTH).
  - MSUB/MSUBU: {HI,LO} −= product, modulo 2^(2·WIDTH).
  - Accumulation uses HI/LO as they stand at that final edge.
- **DIV:** restoring division on operand magnitudes, one quotient bit per cycle, MSB first. On the edge where count = 1:
  - LO = quotient, HI = remainder.
  - Signed: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Signed MIN / −1: LO = MIN, HI = 0.
  - Divisor 0: HI/LO unchanged, but full WIDTH busy cycles are still spent.
- **Any non-NOOP `op` while busy:** ignored, including MTHI/MTLO (the pipeline never issues these).
- **`cancel`:** highest synchronous priority.
  - Whatever `op` is presented that cycle has no effect.
  - If busy, return to IDLE at that edge; HI/LO unchanged.
- **`reset` asserted mid-operation:** immediately IDLE, `busy` = 0, HI/LO = 0.

## Timing
- Start op accepted at edge E0: `busy` = 1 from E0 for exactly N cycles (N = MUL_LATENCY or WIDTH).
- HI/LO update and `busy` fall at the same edge, E0 + N. The result is readable in the cycle after that edge.
- MTHI/MTLO: HI/LO visible the cycle after the edge; `busy` never rises.
- `start` is combinational from `op`, so the stall begins in the issue cycle.
- `cancel` at edge Ek during busy: `busy` = 0 from Ek.
- Back-to-back start ops: the second is accepted only once `busy` = 0. The earliest acceptance edge is E0 + N, since the hazard unit holds the second op while `busy` = 1.

## Structure
- Opcodes `MDUOP_*`, `MDUOP_SIZE`, and the default latency constant go in `macros.v`, shared with the decoder and hazard unit. Add MADD, MADDU, MSUB, MSUBU codes there.
- FSM state encodings are local parameters.
- Sub-module `mdu_div_iter` holds the restoring divider datapath: partial remainder, quotient shift register, sign fix-up. It has a start/abort interface and a done pulse.
- The multiplier is a behavioural product held for the latency count.
- Counter width: $clog2(max(WIDTH, MUL_LATENCY) + 1).

## Test plan
All scenarios use WIDTH = 32, MUL_LATENCY = 5.
- **MULT:** 0xFFFFFFFD × 7 → `busy` high 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULTU 0xFFFFFFFF × 2 → HI = 1, LO = 0xFFFFFFFE.
- **Divide:**
  - DIVU 100/7 → `busy` 32 cycles, LO = 14, HI = 2.
  - DIV −7/2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Divide by zero:** MTHI 0x1234, MTLO 0x5678, then DIV 9/0 → `busy` 32 cycles, HI = 0x1234, LO = 0x5678.
- **Accumulate:** MTHI 0, MTLO 5, MADD 3×4 → HI = 0, LO = 17. Then MSUBU 1×18 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFF.
- **Cancel:** cancel on cycle 10 of a DIV → `busy` low next cycle, HI/LO unchanged. MTLO 9 with cancel in the same cycle → LO unchanged.
- **Reset:** async reset pulse between edges mid-MULT → `busy`, HI, LO = 0 before the next edge. MTHI while busy → ignored.
